// File: rtl/width_upsizer.sv
// Narrow-to-wide serial-to-parallel packer: RATIO beats of IN_W bits form one word,
// with valid/ready on both sides, early close via last_in and a per-lane keep mask.
module width_upsizer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IN_W-1:0]         data_in,
  input  logic                    valid_in,
  input  logic                    last_in,
  output logic                    ready_out,
  output logic [IN_W*RATIO-1:0]   data_out,
  output logic                    valid_out,
  output logic [RATIO-1:0]        keep_out,
  output logic                    last_out,
  input  logic                    ready_in
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] lane;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] acc_next;
  logic [RATIO-1:0] acc_keep_reg;
  logic [RATIO-1:0] acc_keep_next;
  logic [RATIO-1:0] lane_hot;
  logic [OUT_W-1:0] data_out_reg;
  logic [RATIO-1:0] keep_out_reg;
  logic             valid_out_reg;
  logic             last_out_reg;
  logic             accept;
  logic             closing;

  assign ready_out = !reset && (!valid_out_reg || ready_in);
  assign accept    = valid_in && ready_out;
  assign closing   = last_in || (cnt_reg == CNT_MAX);
  assign lane      = MSB_FIRST ? (CNT_MAX - cnt_reg) : cnt_reg;

  // Accumulator with the current beat merged into its lane; unfilled lanes stay zero
  // because the accumulator is cleared whenever a word closes.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lane_hot[gi] = (lane == CNT_W'(gi));
      assign acc_next[gi*IN_W +: IN_W] = lane_hot[gi] ? data_in : acc_reg[gi*IN_W +: IN_W];
    end
  endgenerate

  assign acc_keep_next = acc_keep_reg | lane_hot;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      acc_keep_reg  <= '0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      last_out_reg  <= 1'b0;
    end else begin
      if (valid_out_reg && ready_in) begin
        valid_out_reg <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          data_out_reg  <= acc_next;
          keep_out_reg  <= acc_keep_next;
          last_out_reg  <= last_in;
          valid_out_reg <= 1'b1;
          acc_reg       <= '0;
          acc_keep_reg  <= '0;
          cnt_reg       <= '0;
        end else begin
          acc_reg      <= acc_next;
          acc_keep_reg <= acc_keep_next;
          cnt_reg      <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign data_out  = data_out_reg;
  assign keep_out  = keep_out_reg;
  assign valid_out = valid_out_reg;
  assign last_out  = last_out_reg;

endmodule

// File: tb/tb_width_upsizer.sv
// Scoreboard bench: one MSB-first and one LSB-first upsizer share the same stimulus;
// a beat-list reference model predicts every output word.
module tb_width_upsizer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  data_in = '0;
  logic             valid_in = 1'b0;
  logic             last_in = 1'b0;
  logic             ready_in = 1'b1;

  logic             ready_m, valid_m, last_m;
  logic [OUT_W-1:0] data_m;
  logic [RATIO-1:0] keep_m;
  logic             ready_l, valid_l, last_l;
  logic [OUT_W-1:0] data_l;
  logic [RATIO-1:0] keep_l;

  int tests = 0;
  int fails = 0;

  word_t           q_m[$];
  word_t           q_l[$];
  logic [IN_W-1:0] beats[$];
  logic            rst_prev = 1'b0;
  logic            close_prev = 1'b0;
  logic            rand_done;

  always #5 clk = ~clk;

  width_upsizer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(ready_m), .data_out(data_m), .valid_out(valid_m), .keep_out(keep_m),
    .last_out(last_m), .ready_in(ready_in)
  );

  width_upsizer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(ready_l), .data_out(data_l), .valid_out(valid_l), .keep_out(keep_l),
    .last_out(last_l), .ready_in(ready_in)
  );

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted beats, close a word on last_in or RATIO beats.
  always @(negedge clk) begin
    logic            acc, l, rs;
    logic [IN_W-1:0] d;
    word_t           wm, wl;
    chk("ready_msb", ready_m, !reset && (!valid_m || ready_in));
    chk("ready_lsb", ready_l, !reset && (!valid_l || ready_in));
    if (rst_prev) begin
      chk("rst_valid", {valid_m, valid_l}, 0);
      chk("rst_data", data_m | data_l, 0);
      chk("rst_keep", keep_m | keep_l, 0);
      chk("rst_last", {last_m, last_l}, 0);
    end
    if (close_prev) begin
      chk("latency_msb", valid_m, 1);
      chk("latency_lsb", valid_l, 1);
    end
    acc = valid_in && ready_m && !reset;
    d = data_in;
    l = last_in;
    rs = reset;
    rst_prev = rs;
    close_prev = 1'b0;
    #1;
    if (rs) begin
      beats.delete();
      q_m.delete();
      q_l.delete();
    end else if (acc) begin
      beats.push_back(d);
      if (l || beats.size() == RATIO) begin
        wm = '{data: '0, keep: '0, last: l};
        wl = '{data: '0, keep: '0, last: l};
        for (int i = 0; i < beats.size(); i++) begin
          wm.data[(RATIO-1-i)*IN_W +: IN_W] = beats[i];
          wm.keep[RATIO-1-i] = 1'b1;
          wl.data[i*IN_W +: IN_W] = beats[i];
          wl.keep[i] = 1'b1;
        end
        q_m.push_back(wm);
        q_l.push_back(wl);
        beats.delete();
        close_prev = 1'b1;
      end
    end
  end

  // Output monitor: pop on transfer, compare against the head while stalled.
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      if (valid_m) begin
        if (q_m.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_msb: got %h, expected no word", data_m);
        end else begin
          w = q_m[0];
          chk("data_msb", data_m, w.data);
          chk("keep_msb", keep_m, w.keep);
          chk("last_msb", last_m, w.last);
          if (ready_in) void'(q_m.pop_front());
        end
      end
      if (valid_l) begin
        if (q_l.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_lsb: got %h, expected no word", data_l);
        end else begin
          w = q_l[0];
          chk("data_lsb", data_l, w.data);
          chk("keep_lsb", keep_l, w.keep);
          chk("last_lsb", last_l, w.last);
          if (ready_in) void'(q_l.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    valid_in = 1'b1;
    data_in = d;
    last_in = l;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (ready_m) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL send_timeout: beat %h not accepted, expected acceptance", d);
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0] v1 [4] = '{8'h2F, 8'h5E, 8'h8D, 8'hBC};
    logic [IN_W-1:0] v3 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Full word, then early termination followed by a word starting at lane 3.
    for (int i = 0; i < 4; i++) send(v1[i], 1'b0);
    idle(3);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i), 1'b0);
    send(8'h2F, 1'b0); send(8'h5E, 1'b1);
    idle(3);

    // Backpressure: hold word 01020304, stalled beats 11..44 must all arrive once.
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    ready_in = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(v3[i], 1'b0);
      begin repeat (6) begin @(posedge clk); #1; end ready_in = 1'b1; end
    join
    idle(3);

    // Reset mid-word discards the partial word.
    send(8'h77, 1'b0); send(8'h78, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(8'h10 * 8'(i + 1), 1'b0);
    idle(3);

    // Gapped input, then single-beat words back to back (output stays valid).
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 2));
      send(8'(i), 1'b0);
    end
    for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), 1'b1);
    idle(3);

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send(8'($urandom), ($urandom_range(0, 4) == 0));
        end
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        ready_in = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
      end
    join
    ready_in = 1'b1;
    idle(10);

    chk("drain_msb", 32'(q_m.size()), 0);
    chk("drain_lsb", 32'(q_l.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/width_upsizer.md
Name: width_upsizer

Overview:
- Parametrised narrow-to-wide serial-to-parallel converter; generalises the fixed 8-to-32 mux to any IN_W and RATIO on a single clock.
- Packs RATIO consecutive accepted input beats into one output word.
- Adds a valid/ready handshake on both sides, selectable lane order, early word termination via last_in, and a per-lane keep mask.
- Sits between a byte-wide serial front end and the wide datapath.

Parameters:
- IN_W, 8, input beat width in bits (>=1).
- RATIO, 4, input beats per output word (>=2); OUT_W = IN_W*RATIO.
- MSB_FIRST, 1, 1: first beat lands in the most-significant lane; 0: first beat lands in lane 0 (LSBs).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  IN_W  input beat.
- valid_in  input  1  data_in/last_in valid this cycle.
- last_in  input  1  current beat ends the word early (packet end).
- ready_out  output  1  block accepts a beat this cycle.
- data_out  output  OUT_W  packed word.
- valid_out  output  1  data_out/keep_out/last_out valid.
- keep_out  output  RATIO  bit i=1 means lane data_out[i*IN_W +: IN_W] holds a received beat.
- last_out  output  1  word was closed by last_in.
- ready_in  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (reset=1 at posedge):
  - valid_out=0, data_out=0, keep_out=0, last_out=0.
  - Lane counter cnt=0; accumulator acc=0; acc_keep=0.
  - ready_out=0 combinationally while reset=1.
  - Reset mid-word discards the partial word, with no output.
- ready_out = !reset && (!valid_out || ready_in). It is combinational and must not depend on valid_in.
- Accept: valid_in && ready_out at posedge. Lane index L = MSB_FIRST ? RATIO-1-cnt : cnt.
- Non-closing beat (cnt < RATIO-1 and last_in=0):
  - acc[L] <= data_in; acc_keep[L] <= 1; cnt <= cnt+1.
- Closing beat (cnt == RATIO-1 or last_in=1):
  - At the same edge, the output register loads data_out = acc with lane L replaced by data_in.
  - Unfilled lanes are forced to 0.
  - keep_out = acc_keep | (1<<L); last_out = last_in; valid_out <= 1.
  - Then acc <= 0, acc_keep <= 0, cnt <= 0.
- Latency: valid_out rises in the cycle after the edge that accepted the closing beat.
- Throughput: one beat per cycle sustained with ready_in=1; one word per RATIO beats.
- Output hold: while valid_out && !ready_in, data_out/keep_out/last_out/valid_out are held stable and ready_out=0.
- Word transfer: the word transfers on a posedge where valid_out && ready_in. If no closing beat is accepted at that edge, valid_out <= 0.
- Simultaneous transfer and closing beat: the new word overwrites the output register, valid_out stays 1, and there is no bubble.
- Beats presented while ready_out=0 are not consumed; upstream holds them.
- last_in on the first beat of a word is legal: it produces a single-lane word.
- data_out is don't-care-free: zeros in non-kept lanes always.
- Counter width is $clog2(RATIO); cnt never exceeds RATIO-1.

Test Plan (IN_W=8, RATIO=4, MSB_FIRST=1 unless noted):
1. Full word, ready_in=1:
   - Stimulus: beats 2F,5E,8D,BC on 4 consecutive cycles, last_in=0.
   - Response: one cycle after the 4th accept, data_out=32'h2F5E8DBC, keep_out=4'b1111, last_out=0, valid_out high for exactly 1 cycle.
2. Early termination:
   - Stimulus: beats AA, BB with last_in=1 on BB.
   - Response: data_out=32'hAABB0000, keep_out=4'b1100, last_out=1. The next word starts at lane 3.
3. Backpressure:
   - Stimulus: ready_in=0 after a full word 01,02,03,04.
   - Response: valid_out=1 with data_out=32'h01020304 held stable and ready_out=0 for N cycles. Beats 11,22,33,44 held on data_in are not consumed.
   - Then raise ready_in. Response: the held word transfers, the 4 beats are accepted, and the next word is 32'h11223344 with no lost or duplicated beats.
4. MSB_FIRST=0:
   - Stimulus: beats 2F,5E,8D,BC.
   - Response: data_out=32'hBC8D5E2F. With last_in on beat 2 (beats 2F,5E), data_out=32'h00005E2F and keep_out=4'b0011.
5. Reset mid-word:
   - Stimulus: accept 2 beats, assert reset for 1 cycle, then send 4 beats 10,20,30,40.
   - Response: ready_out=0 during reset, no output from the partial word, next data_out=32'h10203040, keep_out=4'b1111.
6. Gapped input and back-to-back words:
   - Stimulus: random valid_in gaps over 8 beats 00..07, ready_in=1.
   - Response: data_out=32'h00010203 then 32'h04050607, each valid for 1 cycle.
   - Stimulus: word 2's closing beat accepted on the same edge word 1 transfers.
   - Response: valid_out stays high continuously.
